// File: rtl/stream_take_sum_pkg.sv
// ---------------------------------------------------------------------------
// stream_take_sum_pkg
// Shared definitions for the stream_take_sum consumer:
//   N_W      - width of data, count and sum (the codebase intN width)
//   state_t  - FSM state encoding for the top-level controller
// ---------------------------------------------------------------------------
package stream_take_sum_pkg;

    localparam int N_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/stream_take_sum_if.sv
// ---------------------------------------------------------------------------
// stream_take_sum_if
// Handshake bundle for stream_take_sum.
//   start channel : in_valid / in_ready / dIn (element count)
//   data stream   : sIn / sIn_valid / sIn_ready
//   result channel: out_valid / out_ready / dOut (sum)
// Modports:
//   master - the environment (request source, stream producer, result sink)
//   slave  - the stream_take_sum block
// ---------------------------------------------------------------------------
interface stream_take_sum_if;
    import stream_take_sum_pkg::*;

    logic           in_valid;
    logic           in_ready;
    logic [N_W-1:0] dIn;
    logic [N_W-1:0] sIn;
    logic           sIn_valid;
    logic           sIn_ready;
    logic           out_valid;
    logic           out_ready;
    logic [N_W-1:0] dOut;

    modport master (
        output in_valid, dIn, sIn, sIn_valid, out_ready,
        input  in_ready, sIn_ready, out_valid, dOut
    );

    modport slave (
        input  in_valid, dIn, sIn, sIn_valid, out_ready,
        output in_ready, sIn_ready, out_valid, dOut
    );

endinterface

// File: rtl/stream_acc_n.sv
// ---------------------------------------------------------------------------
// stream_acc_n
// Down-counter plus wrapping accumulator.
// Ports:
//   clk, nrst  - clock, asynchronous active-low reset
//   i_clear    - zero the accumulator
//   i_load     - load the remaining-beat counter from i_count
//   i_beat     - one beat accepted: acc += i_data, remaining -= 1
//   i_count    - element count to load
//   i_data     - beat data
//   o_acc      - current accumulator value
//   o_last     - remaining == 1, i.e. the next accepted beat is the final one
// ---------------------------------------------------------------------------
module stream_acc_n
    import stream_take_sum_pkg::*;
(
    input  logic           clk,
    input  logic           nrst,
    input  logic           i_clear,
    input  logic           i_load,
    input  logic           i_beat,
    input  logic [N_W-1:0] i_count,
    input  logic [N_W-1:0] i_data,
    output logic [N_W-1:0] o_acc,
    output logic           o_last
);

    logic [N_W-1:0] r_remaining;
    logic [N_W-1:0] r_acc;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_remaining <= '0;
            r_acc       <= '0;
        end else begin
            // Sum is kept at N_W bits: overflow wraps modulo 2^N_W.
            if (i_clear)
                r_acc <= '0;
            else if (i_beat)
                r_acc <= r_acc + i_data;

            if (i_load)
                r_remaining <= i_count;
            else if (i_beat)
                r_remaining <= r_remaining - 1'b1;
        end
    end

    assign o_acc  = r_acc;
    assign o_last = (r_remaining == N_W'(1));

endmodule

// File: rtl/stream_take_sum.sv
// ---------------------------------------------------------------------------
// stream_take_sum
// Accepts an element count N on the start channel, consumes exactly N beats
// from the input stream, and returns their sum (mod 2^N_W) on the result
// channel. The stream is back-pressured whenever the block is not collecting.
// Ports:
//   clk   - system clock
//   nrst  - asynchronous active-low reset; aborts any operation in flight
//   bus   - stream_take_sum_if.slave (start, stream and result channels)
// All outputs are registers, so no input reaches a ready/valid combinationally.
// ---------------------------------------------------------------------------
module stream_take_sum
    import stream_take_sum_pkg::*;
(
    input  logic             clk,
    input  logic             nrst,
    stream_take_sum_if.slave bus
);

    state_t         r_state;
    logic           r_in_ready;
    logic           r_sin_ready;
    logic           r_out_valid;
    logic [N_W-1:0] r_dout;

    logic           w_start;
    logic           w_beat;
    logic [N_W-1:0] w_acc;
    logic           w_last;

    // r_in_ready is high exactly in IDLE, r_sin_ready exactly in RUN.
    assign w_start = r_in_ready && bus.in_valid;
    assign w_beat  = r_sin_ready && bus.sIn_valid;

    stream_acc_n u_acc (
        .clk     (clk),
        .nrst    (nrst),
        .i_clear (w_start),
        .i_load  (w_start),
        .i_beat  (w_beat),
        .i_count (bus.dIn),
        .i_data  (bus.sIn),
        .o_acc   (w_acc),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_sin_ready <= 1'b0;
            r_out_valid <= 1'b0;
            r_dout      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_in_ready <= 1'b0;
                        if (bus.dIn == '0) begin
                            // Empty request: result is 0 without touching the stream.
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_dout      <= '0;
                        end else begin
                            r_state     <= RUN;
                            r_sin_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_beat && w_last) begin
                        // Capture the sum including the final beat so the
                        // result is valid in the very next cycle.
                        r_state     <= DONE;
                        r_sin_ready <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_dout      <= w_acc + bus.sIn;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_sin_ready <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.sIn_ready = r_sin_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.dOut      = r_dout;

endmodule

// File: tb/tb_stream_take_sum.sv
// ---------------------------------------------------------------------------
// tb_stream_take_sum
// Self-checking bench for stream_take_sum. Directed scenarios plus a
// randomized run; expected sums come from summing the offered beat values.
// ---------------------------------------------------------------------------
module tb_stream_take_sum;
    import stream_take_sum_pkg::*;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    stream_take_sum_if bus ();

    stream_take_sum dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Stream source: beat values in order, optional explicit valid pattern,
    // random stall percentage once the pattern is exhausted.
    logic [7:0] src_data[$];
    bit         src_pat[$];
    int         stall_pct = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.dIn       = '0;
        bus.sIn       = '0;
        bus.sIn_valid = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    // Reference: sum of the first n offered beats, modulo 256.
    function automatic logic [7:0] model_sum(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(src_data[i]);
        return 8'(s % 256);
    endfunction

    // Drives one request and observes it; callers compare the results.
    task automatic run_req(input logic [7:0] n, input int hold,
                           output int beats, output logic [7:0] res,
                           output bit got_result, output bit lat_ok,
                           output bit hold_ok, output bit post_ok);
        int  budget;
        int  idx;
        int  k;
        bit  v;
        bit  final_edge;
        beats = 0; res = '0; got_result = 0; lat_ok = 1; hold_ok = 1; post_ok = 0;
        idx = 0; k = 0;
        budget = 20;
        while (!bus.in_ready && budget > 0) begin step(); budget--; end
        bus.in_valid = 1'b1;
        bus.dIn      = n;
        step();
        bus.in_valid = 1'b0;
        bus.dIn      = 8'($urandom);
        final_edge   = (n == 0);
        for (int c = 0; c < 1200 && !got_result; c++) begin
            if (bus.out_valid) begin
                got_result = 1;
                res        = bus.dOut;
                if (!final_edge) lat_ok = 0;
            end else begin
                if (final_edge) lat_ok = 0;
                v = (k < src_pat.size()) ? src_pat[k] : ($urandom_range(99) >= stall_pct);
                k++;
                bus.sIn_valid = v;
                bus.sIn       = (idx < src_data.size()) ? src_data[idx] : 8'($urandom);
                final_edge    = 0;
                if (v && bus.sIn_ready) begin
                    idx++;
                    beats++;
                    final_edge = (beats == int'(n));
                end
                step();
            end
        end
        if (got_result) begin
            // Upstream keeps offering excess beats; none may be taken.
            bus.sIn_valid = 1'b1;
            for (int h = 0; h < hold; h++) begin
                if (!bus.out_valid || bus.dOut !== res || bus.in_ready || bus.sIn_ready)
                    hold_ok = 0;
                step();
            end
            if (!bus.out_valid || bus.dOut !== res || bus.in_ready || bus.sIn_ready)
                hold_ok = 0;
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
            bus.sIn_valid = 1'b0;
            post_ok = !bus.out_valid && bus.in_ready && !bus.sIn_ready;
        end
        $display("req n=%0d beats=%0d dOut=%0d got=%0b", n, beats, res, got_result);
    endtask

    task automatic test_reset();
        idle_inputs();
        nrst = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({bus.in_ready, bus.sIn_ready, bus.out_valid, bus.dOut} !== {3'b100, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_held: rdy/srdy/ov/dOut=%b/%b/%b/%0d expected 1/0/0/0",
                     bus.in_ready, bus.sIn_ready, bus.out_valid, bus.dOut);
        end
        #3 nrst = 1'b1;
        step();
        n_checks++;
        if ({bus.in_ready, bus.sIn_ready, bus.out_valid, bus.dOut} !== {3'b100, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_release: rdy/srdy/ov/dOut=%b/%b/%b/%0d expected 1/0/0/0",
                     bus.in_ready, bus.sIn_ready, bus.out_valid, bus.dOut);
        end
    endtask

    task automatic test_directed(input string name, input logic [7:0] n,
                                 input logic [7:0] exp_sum, input int hold);
        int beats; logic [7:0] res; bit got, lat, hok, pok;
        run_req(n, hold, beats, res, got, lat, hok, pok);
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL %s_timeout: no out_valid, required one", name); end
        n_checks++;
        if (res !== exp_sum) begin n_fail++; $display("FAIL %s_sum: dOut=%0d expected %0d", name, res, exp_sum); end
        n_checks++;
        if (beats != int'(n)) begin n_fail++; $display("FAIL %s_beats: consumed %0d expected %0d", name, beats, n); end
        n_checks++;
        if (!lat) begin n_fail++; $display("FAIL %s_latency: out_valid timing wrong, required 1 cycle after last beat/start", name); end
        n_checks++;
        if (!hok) begin n_fail++; $display("FAIL %s_hold: result not stable or ready asserted in DONE", name); end
        n_checks++;
        if (!pok) begin n_fail++; $display("FAIL %s_post: after result handshake out_valid/in_ready/sIn_ready wrong, required 0/1/0", name); end
    endtask

    task automatic test_basic();
        src_data = {8'd42, 8'd42, 8'd42, 8'd42, 8'd42}; src_pat = {}; stall_pct = 0;
        test_directed("basic", 8'd3, 8'd126, 0);
    endtask

    task automatic test_wrap();
        src_data = {8'd100, 8'd100, 8'd100, 8'd100, 8'd100}; src_pat = {}; stall_pct = 0;
        test_directed("wrap", 8'd4, 8'd144, 0);
    endtask

    task automatic test_zero();
        src_data = {8'd77, 8'd77}; src_pat = {}; stall_pct = 0;
        test_directed("zero", 8'd0, 8'd0, 1);
    endtask

    task automatic test_stalls();
        src_data = {8'd5, 8'd7, 8'd50}; src_pat = {1'b1, 1'b0, 1'b0, 1'b1}; stall_pct = 0;
        test_directed("stalls", 8'd2, 8'd12, 4);
        src_pat = {};
    endtask

    task automatic test_back_to_back();
        int budget = 20;
        idle_inputs();
        while (!bus.in_ready && budget > 0) begin step(); budget--; end
        bus.in_valid = 1'b1; bus.dIn = 8'd2;
        step();
        bus.in_valid = 1'b0;
        bus.sIn_valid = 1'b1; bus.sIn = 8'd20;
        step();
        bus.sIn = 8'd22;
        step();
        n_checks++;
        if (!bus.out_valid || bus.dOut !== 8'd42) begin
            n_fail++; $display("FAIL b2b_first: ov=%b dOut=%0d expected 1/42", bus.out_valid, bus.dOut);
        end
        // Take the result and present the next request in the same cycle.
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.dIn = 8'd1; bus.sIn = 8'd9;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_no_early_start: in_ready=%b expected 0", bus.in_ready);
        end
        step();
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle: in_ready=%b ov=%b expected 1/0", bus.in_ready, bus.out_valid);
        end
        step();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.sIn_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_accept: in_ready=%b sIn_ready=%b expected 0/1", bus.in_ready, bus.sIn_ready);
        end
        step();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.dOut !== 8'd9) begin
            n_fail++; $display("FAIL b2b_second: ov=%b dOut=%0d expected 1/9", bus.out_valid, bus.dOut);
        end
        $display("req b2b second dOut=%0d", bus.dOut);
        bus.out_ready = 1'b1; bus.sIn_valid = 1'b0;
        step();
        idle_inputs();
    endtask

    task automatic test_reset_mid_run();
        bit seen_ov = 0;
        idle_inputs();
        bus.in_valid = 1'b1; bus.dIn = 8'd5;
        step();
        bus.in_valid = 1'b0;
        bus.sIn_valid = 1'b1; bus.sIn = 8'd3;
        step();
        step();
        #2 nrst = 1'b0;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.sIn_ready, bus.out_valid, bus.dOut} !== {3'b100, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_async: rdy/srdy/ov/dOut=%b/%b/%b/%0d expected 1/0/0/0",
                     bus.in_ready, bus.sIn_ready, bus.out_valid, bus.dOut);
        end
        #1 nrst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.out_valid) seen_ov = 1;
        end
        n_checks++;
        if (seen_ov) begin n_fail++; $display("FAIL reset_abort: out_valid=1 after abort, expected 0"); end
        idle_inputs();
        src_data = {8'd1, 8'd2, 8'd60}; src_pat = {}; stall_pct = 0;
        test_directed("after_reset", 8'd2, 8'd3, 0);
    endtask

    task automatic test_random();
        int beats; logic [7:0] res; bit got, lat, hok, pok;
        logic [7:0] n;
        logic [7:0] exp_sum;
        stall_pct = 30; src_pat = {};
        for (int it = 0; it < 12; it++) begin
            if (it == 3)      n = 8'd0;
            else if (it == 7) n = 8'd255;
            else              n = 8'($urandom_range(1, 16));
            src_data = {};
            for (int i = 0; i < int'(n) + 3; i++) src_data.push_back(8'($urandom));
            exp_sum = model_sum(int'(n));
            run_req(n, $urandom_range(0, 3), beats, res, got, lat, hok, pok);
            n_checks++;
            if (!got || res !== exp_sum || beats != int'(n) || !lat || !hok || !pok) begin
                n_fail++;
                $display("FAIL random_%0d: n=%0d got=%b dOut=%0d beats=%0d lat=%b hold=%b post=%b expected dOut=%0d beats=%0d",
                         it, n, got, res, beats, lat, hok, pok, exp_sum, n);
            end
        end
        stall_pct = 0;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic();
        test_wrap();
        test_zero();
        test_stalls();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_take_sum.md
Name: stream_take_sum

Overview:
- Consumer end of the `stream` interface that `tests_repeat_int`-style producers drive.
- A start handshake accepts an element count N. The block then consumes exactly N beats from the input stream, sums them modulo 2^intN, and returns the sum as an `int` on a valid/ready result port.
- It sits downstream of stream generators (repeat, map, etc.). It turns a possibly infinite stream into a scalar result and back-pressures the producer whenever it is not collecting.

Parameters:
- N_W, 8: width of data, count and sum; matches the codebase `intN`.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- nrst  in  1  asynchronous, active-low reset.
- in_valid  in  1  start request valid.
- in_ready  out  1  block can accept a start request.
- dIn  in  N_W  element count N, unsigned, sampled on start handshake.
- sIn  in  N_W  stream data beat.
- sIn_valid  in  1  stream beat valid.
- sIn_ready  out  1  block accepts stream beat.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- dOut  out  N_W  sum result.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `nrst` is asynchronous, active-low.
- Reset values: state=IDLE, remaining=0, acc=0, in_ready=1, sIn_ready=0, out_valid=0, dOut=0.
- Reset asserted mid-operation aborts the operation immediately. The partial sum is discarded. No out_valid is produced for the aborted request.
- Handshake rule: a transfer occurs on a rising edge where valid&&ready. Valid may not depend combinationally on ready. The block's ready outputs are registered-state decodes only, with no combinational path from any input.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, sIn_ready=0, out_valid=0.
  - On in_valid: latch remaining=dIn and clear acc=0.
  - If dIn==0, go to DONE; the result is 0 and no beats are consumed.
  - Otherwise go to RUN.
- RUN:
  - in_ready=0, sIn_ready=1, out_valid=0.
  - Per accepted beat: acc<=acc+sIn, truncated to N_W bits (wrap, no saturation), and remaining<=remaining-1.
  - When a beat is accepted with remaining==1, go to DONE.
  - Cycles with sIn_valid=0 change nothing. Stalls of any length are legal.
- DONE:
  - out_valid=1, dOut=acc, held stable until out_ready.
  - in_ready=0, sIn_ready=0.
  - On out_ready, go to IDLE.
- Latency:
  - Start handshake to first possible beat acceptance: 1 cycle.
  - Last beat acceptance to out_valid: 1 cycle.
  - Minimum command-to-result time for N beats with continuous sIn_valid: N+1 cycles. For N=0 it is 1 cycle.
  - Throughput: one beat per cycle in RUN.
- Back-to-back requests: a new start is accepted no earlier than the cycle after the result handshake, because in_ready=1 only in IDLE. This gives one idle cycle between requests.
- Excess beats: beats beyond N are never consumed. sIn_ready is 0 outside RUN, so an infinite upstream stream simply stalls.
- dOut outside DONE: holds the last result (0 after reset). Its value is meaningful only when out_valid=1.
- Maximum count: N=2^N_W-1 is supported. remaining is N_W bits.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Width default N_W tied to `intN`.
  - The stream port bundle macro already used for `stream` types.
- Sub-module `stream_acc_n`: down-counter plus wrapping accumulator.
  - Inputs: clear, load count, beat-enable.
  - Outputs: acc, last flag.
- The top level holds the FSM and the handshake decode.

Test Plan:
- Reset then idle: hold nrst=0 for 3 cycles, release. Expect in_ready=1, sIn_ready=0, out_valid=0, dOut=0. Pulsing nrst low in RUN returns these values asynchronously, within the same cycle.
- Basic sum: dIn=3 with in_valid for 1 cycle, continuous sIn=42 valid. Expect exactly 3 beats consumed, sIn_ready drops after the third, out_valid 1 cycle later with dOut=126.
- Wrap: dIn=4, sIn=100 constant. Expect dOut=400 mod 256=144.
- Zero count: dIn=0. Expect out_valid the next cycle with dOut=0 and sIn_ready never asserted.
- Stalls and back-pressure:
  - dIn=2 with sIn_valid toggling 1,0,0,1 (values 5, then 7). Expect dOut=12.
  - Hold out_ready=0 for 4 cycles: out_valid and dOut stay stable, and in_ready=0 throughout.
- Back-to-back: the second request, dIn=1 with sIn=9, is presented as soon as the first result is taken. Expect it accepted the cycle after the result handshake, and dOut=9.
